// File: rtl/z80_bus_responder.sv
// Memory/IO-side responder for the Z80 pin bus: decodes strobe cycles, stretches them
// with nWAIT until the backing store acknowledges, and drives D for reads and INTA.
module z80_bus_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic        nWAIT,
    output logic [15:0] mem_addr,
    output logic        mem_io,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DRAIN} state_t;
    typedef enum logic [1:0] {K_READ, K_WRITE, K_INTA} kind_t;

    state_t             state;
    state_t             state_nx;
    kind_t              kind;
    kind_t              start_kind_c;
    logic               start_c;
    logic               strobe_held_c;
    logic               hold_done_c;
    logic               access_done_c;
    logic               drive_c;
    logic [CNT_W-1:0]   cnt;
    logic               ack_seen;
    logic [7:0]         rdata_q;

    // Cycle-start decode; INTA wins over the read/write strobes.
    always_comb begin
        start_c      = 1'b0;
        start_kind_c = K_READ;
        if (!nIORQ && !nM1) begin
            start_c      = 1'b1;
            start_kind_c = K_INTA;
        end else if ((nMREQ ^ nIORQ) && (nRD ^ nWR)) begin
            start_c      = 1'b1;
            start_kind_c = nRD ? K_WRITE : K_READ;
        end
    end

    always_comb begin
        strobe_held_c = 1'b0;
        hold_done_c   = 1'b0;
        case (kind)
            K_READ:  strobe_held_c = !nRD;
            K_WRITE: strobe_held_c = !nWR;
            K_INTA:  strobe_held_c = !nIORQ;
            default: strobe_held_c = 1'b0;
        endcase
        hold_done_c   = (kind == K_INTA) ? nIORQ : (nRD && nWR);
        access_done_c = (cnt == '0) && (ack_seen || mem_ack || kind == K_INTA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_c) state_nx = ACCESS;
            ACCESS:  if (access_done_c) state_nx = strobe_held_c ? HOLD : IDLE;
            HOLD:    if (hold_done_c) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture at cycle start; request strobes drop on the edge that samples mem_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind      <= K_READ;
            mem_addr  <= 16'h0000;
            mem_io    <= 1'b0;
            mem_wdata <= 8'h00;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            cnt       <= '0;
            ack_seen  <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        kind     <= start_kind_c;
                        mem_addr <= A;
                        mem_io   <= !nIORQ;
                        if (start_kind_c == K_WRITE) mem_wdata <= D;
                        mem_rd   <= (start_kind_c == K_READ);
                        mem_wr   <= (start_kind_c == K_WRITE);
                        cnt      <= CNT_W'(WAIT_STATES);
                        ack_seen <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        ack_seen <= 1'b1;
                        mem_rd   <= 1'b0;
                        mem_wr   <= 1'b0;
                        if (kind == K_READ) rdata_q <= mem_rdata;
                    end
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from the state register so reset releases D at once.
    assign nWAIT   = (state != ACCESS);
    assign drive_c = (state == HOLD) && (kind != K_WRITE);
    assign D       = drive_c ? ((kind == K_INTA) ? INTA_VECTOR : rdata_q) : {8{1'bz}};

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances (0 and 2 wait states) run against
// a cycle-timing model derived from the bus rules, plus literal pins on key counts.
module tb_z80_bus_responder;

    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 2;
    localparam int MEMRD = 0, MEMWR = 1, IORD = 2, IOWR = 3, INTA = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] a [2];
    logic [1:0]  nmreq, niorq, nrd, nwr, nm1, ack, d_oe;
    logic [7:0]  rdata [2];
    logic [7:0]  d_drv [2];

    wire  [7:0]  d0, d1;
    wire  [1:0]  nwait, rd, wr, io;
    wire  [15:0] addr_w [2];
    wire  [7:0]  wdata_w [2];
    wire  [7:0]  d_seen [2];

    assign d0 = d_oe[0] ? d_drv[0] : 8'bz;
    assign d1 = d_oe[1] ? d_drv[1] : 8'bz;
    assign d_seen[0] = d0;
    assign d_seen[1] = d1;

    // Weak pull-down so an undriven data bus reads as 8'h00.
    for (genvar k = 0; k < 8; k++) begin : g_pd
        pulldown pd0 (d0[k]);
        pulldown pd1 (d1[k]);
    end

    z80_bus_responder #(.WAIT_STATES(WS0), .INTA_VECTOR(8'hFF)) dut0 (
        .clk(clk), .reset(reset), .A(a[0]), .D(d0),
        .nMREQ(nmreq[0]), .nIORQ(niorq[0]), .nRD(nrd[0]), .nWR(nwr[0]), .nM1(nm1[0]),
        .nWAIT(nwait[0]), .mem_addr(addr_w[0]), .mem_io(io[0]), .mem_rd(rd[0]),
        .mem_wr(wr[0]), .mem_wdata(wdata_w[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0])
    );

    z80_bus_responder #(.WAIT_STATES(WS1), .INTA_VECTOR(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .A(a[1]), .D(d1),
        .nMREQ(nmreq[1]), .nIORQ(niorq[1]), .nRD(nrd[1]), .nWR(nwr[1]), .nM1(nm1[1]),
        .nWAIT(nwait[1]), .mem_addr(addr_w[1]), .mem_io(io[1]), .mem_rd(rd[1]),
        .mem_wr(wr[1]), .mem_wdata(wdata_w[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1])
    );

    // Expected pin state for the current clock, maintained by the stimulus tasks.
    logic [1:0]  e_nwait, e_rd, e_wr, e_io;
    logic [15:0] e_addr [2];
    logic [7:0]  e_wdata [2];
    logic [7:0]  e_d [2];

    int n_cmp = 0;
    int n_bad = 0;
    int nwait_lo [2];
    int wr_hi [2];
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int i = 0; i < 2; i++) begin
                chk("nwait", i, 16'(nwait[i]), 16'(e_nwait[i]));
                chk("mem_rd", i, 16'(rd[i]), 16'(e_rd[i]));
                chk("mem_wr", i, 16'(wr[i]), 16'(e_wr[i]));
                chk("d_bus", i, 16'(d_seen[i]), 16'(e_d[i]));
                chk("mem_addr", i, addr_w[i], e_addr[i]);
                chk("mem_io", i, 16'(io[i]), 16'(e_io[i]));
                chk("mem_wdata", i, 16'(wdata_w[i]), 16'(e_wdata[i]));
                if (nwait[i] == 1'b0) nwait_lo[i]++;
                if (wr[i] == 1'b1) wr_hi[i]++;
            end
        end
    end

    task automatic set_idle(input int i);
        e_nwait[i] = 1'b1;
        e_rd[i]    = 1'b0;
        e_wr[i]    = 1'b0;
        e_d[i]     = 8'h00;
    endtask

    task automatic bus_release(input int i);
        nmreq[i] = 1'b1;
        niorq[i] = 1'b1;
        nrd[i]   = 1'b1;
        nwr[i]   = 1'b1;
        nm1[i]   = 1'b1;
        d_oe[i]  = 1'b0;
    endtask

    task automatic set_reset_exp();
        for (int i = 0; i < 2; i++) begin
            set_idle(i);
            e_addr[i]  = 16'h0000;
            e_io[i]    = 1'b0;
            e_wdata[i] = 8'h00;
        end
    endtask

    // One CPU bus cycle; ACCESS length is max(ws+1, ack clock), INTA needs no ack.
    task automatic run_cycle(input int i, input int kind, input logic [15:0] addr,
                             input logic [7:0] data, input int ack_at, input int hold,
                             input bit abort);
        int ws, len;
        bit is_rd, is_wr, is_inta, is_io;
        ws      = (i == 0) ? int'(WS0) : int'(WS1);
        is_inta = (kind == INTA);
        is_io   = (kind == IORD) || (kind == IOWR) || is_inta;
        is_rd   = (kind == MEMRD) || (kind == IORD);
        is_wr   = (kind == MEMWR) || (kind == IOWR);
        len     = is_inta ? ws + 1 : ((ws + 1 > ack_at) ? ws + 1 : ack_at);
        nwait_lo[i] = 0;
        wr_hi[i]    = 0;
        @(posedge clk); #1;
        a[i]     = addr;
        nm1[i]   = !is_inta;
        niorq[i] = !is_io;
        nmreq[i] = is_io;
        nrd[i]   = !is_rd;
        nwr[i]   = !is_wr;
        if (is_wr) begin
            d_oe[i]  = 1'b1;
            d_drv[i] = data;
            e_d[i]   = data;
        end
        for (int j = 1; j <= len; j++) begin
            @(posedge clk); #1;
            if (j == 1) begin
                e_addr[i] = addr;
                e_io[i]   = is_io;
                if (is_wr) e_wdata[i] = data;
                d_oe[i] = 1'b0;
                e_d[i]  = 8'h00;
                if (abort) bus_release(i);
            end
            ack[i]     = !is_inta && (j == ack_at);
            rdata[i]   = ack[i] ? data : ~data;
            e_nwait[i] = 1'b0;
            e_rd[i]    = is_rd && (j <= ack_at);
            e_wr[i]    = is_wr && (j <= ack_at);
        end
        if (abort) begin
            @(posedge clk); #1;
            ack[i] = 1'b0;
            set_idle(i);
            @(posedge clk); #1;
            return;
        end
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            set_idle(i);
            e_d[i]   = is_wr ? 8'h00 : (is_inta ? 8'hFF : data);
            ack[i]   = (h == 1) && !is_inta;
            rdata[i] = 8'h99;
            if (h == hold) bus_release(i);
        end
        @(posedge clk); #1;
        ack[i] = 1'b0;
        e_d[i] = 8'h00;
        @(posedge clk); #1;
    endtask

    // Held pattern that must not start a cycle; a stray ack is offered in IDLE too.
    task automatic ignore_pat(input int i, input logic mreq_n, input logic iorq_n,
                              input logic rd_n, input logic wr_n);
        nwait_lo[i] = 0;
        @(posedge clk); #1;
        a[i]     = 16'hDEAD;
        nmreq[i] = mreq_n;
        niorq[i] = iorq_n;
        nrd[i]   = rd_n;
        nwr[i]   = wr_n;
        nm1[i]   = 1'b1;
        ack[i]   = 1'b1;
        rdata[i] = 8'hEE;
        repeat (3) begin
            @(posedge clk); #1;
            ack[i] = 1'b0;
        end
        bus_release(i);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_release(i);
            a[i]     = 16'h0000;
            d_drv[i] = 8'h00;
            ack[i]   = 1'b0;
            rdata[i] = 8'h00;
        end
        set_reset_exp();
        #2;
        chk("rst_nwait", 0, 16'(nwait[0]), 16'h0001);
        chk("rst_mem_rd", 0, 16'(rd[0]), 16'h0000);
        chk("rst_addr", 1, addr_w[1], 16'h0000);
        chk("rst_d", 0, 16'(d0), 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        run_cmp = 1'b1;
        @(posedge clk); #1;

        run_cycle(0, MEMRD, 16'h1234, 8'hA5, 1, 2, 1'b0);
        chk("memrd_wait_clks", 0, 16'(nwait_lo[0]), 16'd1);

        run_cycle(0, MEMWR, 16'h8000, 8'h3C, 3, 1, 1'b0);
        chk("memwr_wait_clks", 0, 16'(nwait_lo[0]), 16'd3);
        chk("memwr_wr_clks", 0, 16'(wr_hi[0]), 16'd3);
        chk("memwr_wdata", 0, 16'(wdata_w[0]), 16'h003C);

        run_cycle(1, IORD, 16'h00FE, 8'h77, 1, 1, 1'b0);
        chk("iord_wait_clks", 1, 16'(nwait_lo[1]), 16'd3);
        chk("iord_io", 1, 16'(io[1]), 16'h0001);

        run_cycle(0, INTA, 16'h0038, 8'h00, 0, 2, 1'b0);
        chk("inta_wait_clks", 0, 16'(nwait_lo[0]), 16'd1);

        ignore_pat(0, 1'b0, 1'b1, 1'b1, 1'b1);
        ignore_pat(0, 1'b0, 1'b1, 1'b0, 1'b0);
        ignore_pat(0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ignored_wait_clks", 0, 16'(nwait_lo[0]), 16'd0);

        run_cycle(1, MEMRD, 16'h4444, 8'h12, 2, 1, 1'b1);
        chk("abort_wait_clks", 1, 16'(nwait_lo[1]), 16'd3);

        run_cycle(1, IOWR, 16'h0010, 8'hC3, 4, 1, 1'b0);
        chk("iowr_wr_clks", 1, 16'(wr_hi[1]), 16'd4);

        // Reset asserted mid-HOLD must release D without waiting for a clock.
        @(posedge clk); #1;
        a[0]     = 16'h2222;
        nmreq[0] = 1'b0;
        nrd[0]   = 1'b0;
        @(posedge clk); #1;
        ack[0]     = 1'b1;
        rdata[0]   = 8'h5E;
        e_addr[0]  = 16'h2222;
        e_io[0]    = 1'b0;
        e_nwait[0] = 1'b0;
        e_rd[0]    = 1'b1;
        @(posedge clk); #1;
        ack[0] = 1'b0;
        set_idle(0);
        e_d[0] = 8'h5E;
        chk("hold_d", 0, 16'(d0), 16'h005E);
        #2;
        reset = 1'b1;
        set_reset_exp();
        #1;
        chk("rst_hold_d", 0, 16'(d0), 16'h0000);
        chk("rst_hold_addr", 0, addr_w[0], 16'h0000);
        chk("rst_hold_nwait", 0, 16'(nwait[0]), 16'h0001);
        @(posedge clk); #1;
        bus_release(0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_cycle(0, MEMRD, 16'hFFFF, 8'h01, 2, 1, 1'b0);
        chk("post_rst_wait_clks", 0, 16'(nwait_lo[0]), 16'd2);

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
